// File: rtl/sram_writer.sv
// Streams a bounded run of words into an SRAM write port.
// Addresses wrap at DATA_DEPTH; abort drops the in-flight beat.
module sram_writer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 16
) (
  input  logic                  clkw,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  abort,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  we,
  output logic                  ce
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    (ADDR_WIDTH+1)'(DATA_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_A =
    ADDR_WIDTH'(DATA_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] ONE_W =
    (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A =
    ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  legal;

  assign legal = (len != '0)
              && (len <= DEPTH_W)
              && ({1'b0, base_addr} < DEPTH_W);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (legal) begin
            state_d = WRITE;
            addr_d  = base_addr;
            rem_d   = len;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WRITE: begin
        // abort wins over a beat handshaked in the same cycle
        if (abort) begin
          state_d = IDLE;
        end else if (s_valid) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = s_data;
          addr_d  = (addr_q == LAST_A) ? '0
                                       : addr_q + ONE_A;
          rem_d   = rem_q - ONE_W;
          cnt_d   = cnt_q + ONE_W;
          if (rem_q == ONE_W) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clkw) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign s_ready  = (state_q == WRITE);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign wr_count = cnt_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign we       = we_q;
  assign ce       = we_q;

endmodule

// File: tb/tb_sram_writer.sv
// Bench for sram_writer: transfer-level model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_sram_writer;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clkw;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          abort;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   wr_count;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          we;
  logic          ce;

  sram_writer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DATA_DEPTH(DEPTH)
  ) dut (
    .clkw(clkw),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .len(len),
    .abort(abort),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .busy(busy),
    .done(done),
    .err(err),
    .wr_count(wr_count),
    .waddr(waddr),
    .wdata(wdata),
    .we(we),
    .ce(ce)
  );

  initial clkw = 1'b0;
  always #5 clkw = ~clkw;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h",
               nm, $time, act, exp);
    end
  endtask

  // Transfer-level model: phase 0 idle, 1 moving words, 2 finishing.
  int   ph     = 0;
  int   t_base = 0;
  int   t_len  = 0;
  int   idx    = 0;
  int   m_cnt  = 0;
  int   m_wa   = 0;
  int   m_wd   = 0;
  logic m_we   = 1'b0;
  logic m_done = 1'b0;
  logic m_err  = 1'b0;
  bit   chk_en = 1'b0;

  always @(posedge clkw) begin
    m_we   = 1'b0;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      ph     = 0;
      m_cnt  = 0;
      m_wa   = 0;
      m_wd   = 0;
      chk_en = 1'b1;
    end else if (ph == 0) begin
      if (start) begin
        if (len >= 1 && len <= DEPTH && base_addr < DEPTH) begin
          ph     = 1;
          t_base = int'(base_addr);
          t_len  = int'(len);
          idx    = 0;
          m_cnt  = 0;
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (ph == 1) begin
      if (abort) begin
        ph = 0;
      end else if (s_valid) begin
        m_we  = 1'b1;
        m_wa  = (t_base + idx) % DEPTH;
        m_wd  = int'(s_data);
        idx   = idx + 1;
        m_cnt = idx;
        if (idx == t_len) begin
          ph     = 2;
          m_done = 1'b1;
        end
      end
    end else begin
      ph = 0;
    end
  end

  typedef struct {
    int a;
    int d;
  } wr_t;

  wr_t wq[$];
  int  n_done    = 0;
  int  n_done_we = 0;
  int  n_err     = 0;

  always @(negedge clkw) begin
    if (chk_en) begin
      check("s_ready", s_ready, ph == 1);
      check("busy", busy, ph != 0);
      check("done", done, m_done);
      check("err", err, m_err);
      check("we", we, m_we);
      check("ce", ce, m_we);
      check("wr_count", wr_count, m_cnt);
      check("waddr", waddr, m_wa);
      check("wdata", wdata, m_wd);
      if (we) wq.push_back('{int'(waddr), int'(wdata)});
      if (done) n_done++;
      if (done && we) n_done_we++;
      if (err) n_err++;
    end
  end

  int ea[$];
  int ed[$];

  task automatic chk_wr(input string nm);
    check({nm, "_nwr"}, wq.size(), ea.size());
    for (int i = 0; i < wq.size() && i < ea.size(); i++) begin
      check({nm, "_addr"}, wq[i].a, ea[i]);
      if (i < ed.size()) check({nm, "_data"}, wq[i].d, ed[i]);
    end
  endtask

  task automatic clr();
    wq.delete();
    ed.delete();
    n_done    = 0;
    n_done_we = 0;
    n_err     = 0;
  endtask

  task automatic idle(input int n);
    start   = 1'b0;
    abort   = 1'b0;
    s_valid = 1'b0;
    repeat (n) @(negedge clkw);
  endtask

  task automatic go(input int b, input int l);
    start     = 1'b1;
    base_addr = AW'(b);
    len       = (AW+1)'(l);
    @(negedge clkw);
    start = 1'b0;
  endtask

  task automatic beat(input bit v, input int d);
    s_valid = v;
    s_data  = DW'(d);
    @(negedge clkw);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    abort     = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    repeat (2) @(negedge clkw);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_ready", s_ready, 0);
    check("rst_we", we, 0);
    check("rst_wcount", wr_count, 0);

    // plain run, valid held
    clr();
    go(2, 3);
    beat(1, 'hA1);
    beat(1, 'hA2);
    beat(1, 'hA3);
    idle(2);
    ea = {2, 3, 4};
    ed = {'hA1, 'hA2, 'hA3};
    chk_wr("run3");
    check("run3_done", n_done, 1);
    check("run3_done_we", n_done_we, 1);
    check("run3_cnt", wr_count, 3);
    check("run3_busy", busy, 0);

    // address wrap
    clr();
    go(14, 4);
    for (int i = 0; i < 4; i++) beat(1, 'h10 + i);
    idle(2);
    ea = {14, 15, 0, 1};
    chk_wr("wrap");
    check("wrap_done", n_done, 1);

    // illegal starts leave count untouched
    clr();
    go(0, 0);
    idle(1);
    go(0, 17);
    idle(1);
    go(16, 1);
    idle(2);
    ea = {};
    chk_wr("illegal");
    check("illegal_err", n_err, 3);
    check("illegal_busy", busy, 0);
    check("illegal_cnt", wr_count, 4);

    // stalls between beats
    clr();
    go(5, 4);
    for (int i = 0; i < 7; i++) beat(i % 2 == 0, 'h50 + i);
    idle(2);
    ea = {5, 6, 7, 8};
    ed = {'h50, 'h52, 'h54, 'h56};
    chk_wr("stall");
    check("stall_done", n_done, 1);
    check("stall_done_we", n_done_we, 1);

    // abort with third handshake
    clr();
    go(0, 8);
    beat(1, 'hB1);
    beat(1, 'hB2);
    abort = 1'b1;
    beat(1, 'hB3);
    abort = 1'b0;
    s_valid = 1'b0;
    check("abort_busy", busy, 0);
    idle(2);
    ea = {0, 1};
    chk_wr("abort");
    check("abort_done", n_done, 0);
    check("abort_cnt", wr_count, 2);

    // reset on second handshake, then a short run
    clr();
    go(3, 5);
    beat(1, 'hC1);
    rst = 1'b1;
    beat(1, 'hC2);
    rst = 1'b0;
    s_valid = 1'b0;
    check("rstmid_we", we, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_cnt", wr_count, 0);
    check("rstmid_waddr", waddr, 0);
    check("rstmid_wdata", wdata, 0);
    go(7, 1);
    beat(1, 'hD1);
    idle(2);
    ea = {3, 7};
    ed = {'hC1, 'hD1};
    chk_wr("rstmid");
    check("rstmid_done", n_done, 1);
    check("rstmid_cnt2", wr_count, 1);

    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      start     = ($urandom_range(0, 3) == 0);
      base_addr = AW'($urandom_range(0, 17));
      len       = (AW+1)'($urandom_range(0, 18));
      abort     = ($urandom_range(0, 29) == 0);
      s_valid   = ($urandom_range(0, 9) < 6);
      s_data    = DW'($urandom);
      rst       = ($urandom_range(0, 149) == 0);
      @(negedge clkw);
    end
    rst = 1'b0;
    idle(25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_writer.md
SRAM_WRITER -- requirements
Module: sram_writer

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, meaning SRAM address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning word width.
REQ-003 The block SHALL have parameter DATA_DEPTH, default 16, meaning number of SRAM words; wrap point.
REQ-004 Port clkw  in  1  write-port clock; all logic on rising edge.
REQ-005 Port rst  in  1  reset, synchronous, active-high.
REQ-006 Port start  in  1  transfer request; sampled in IDLE only.
REQ-007 Port base_addr  in  ADDR_WIDTH  first word address, sampled with start.
REQ-008 Port len  in  ADDR_WIDTH+1  word count, sampled with start; legal 1..DATA_DEPTH.
REQ-009 Port abort  in  1  terminate active transfer.
REQ-010 Port s_valid  in  1  input stream word valid.
REQ-011 Port s_data  in  DATA_WIDTH  input stream word.
REQ-012 Port s_ready  out  1  input stream ready.
REQ-013 Port busy  out  1  transfer in progress.
REQ-014 Port done  out  1  one-cycle pulse, transfer completed.
REQ-015 Port err  out  1  one-cycle pulse, illegal start parameters.
REQ-016 Port wr_count  out  ADDR_WIDTH+1  words written in current/last transfer.
REQ-017 Ports waddr (ADDR_WIDTH), wdata (DATA_WIDTH), we (1), ce (1)  out  SRAM write-port drive, all registered.

Function
REQ-018 FSM states SHALL be IDLE, WRITE, DONE; busy = (state != IDLE).
REQ-019 IDLE: start=1 with 1<=len<=DATA_DEPTH and base_addr<DATA_DEPTH -> WRITE next cycle; load cur_addr=base_addr, remaining=len, wr_count=0.
REQ-020 IDLE: start=1 with len==0, len>DATA_DEPTH or base_addr>=DATA_DEPTH -> err=1 for one cycle, stay IDLE, wr_count unchanged.
REQ-021 start SHALL be ignored in WRITE and DONE.
REQ-022 s_ready SHALL equal (state==WRITE), decoded from state only (no combinational path from inputs).
REQ-023 Beat accepted when s_valid && s_ready at edge N -> at N+1: we=1, ce=1, waddr=cur_addr, wdata=s_data (1-cycle latency).
REQ-024 we and ce SHALL be 0 in every cycle not following an accepted beat; s_valid=0 stalls without penalty.
REQ-025 Per accepted beat: cur_addr = (cur_addr==DATA_DEPTH-1) ? 0 : cur_addr+1; remaining decrements; wr_count increments with the corresponding we.
REQ-026 Accepting the beat with remaining==1 -> DONE next cycle; done=1 in the same cycle as the last we.
REQ-027 DONE SHALL last exactly one cycle, then IDLE; start accepted from the following cycle.
REQ-028 abort=1 in WRITE -> IDLE next cycle, done=0; a beat handshaked in the abort cycle SHALL be discarded (no we); earlier beats' writes complete normally.
REQ-029 abort SHALL be ignored in IDLE and DONE.
REQ-030 wr_count SHALL hold its final value in IDLE until the next legal start.

Reset
REQ-031 rst=1 at an edge -> next cycle state=IDLE, s_ready=0, busy=0, done=0, err=0, we=0, ce=0, waddr=0, wdata=0, wr_count=0.
REQ-032 rst mid-transfer SHALL suppress any write pending from the rst cycle; rst priority over start, abort and handshake.

Verification
REQ-033 start, base_addr=2, len=3, s_valid held 1, data A1,A2,A3 -> we in 3 consecutive cycles at waddr 2,3,4; done with third we; wr_count=3; busy low next cycle.
REQ-034 base_addr=14, len=4 (DATA_DEPTH=16) -> waddr 14,15,0,1 in order.
REQ-035 len=0, then len=17, then base_addr=16 -> err pulse each, busy stays 0, no we.
REQ-036 len=4, s_valid toggling 1,0,1,0,... -> exactly 4 we pulses each one cycle after its handshake; done with the 4th.
REQ-037 len=8, abort asserted with 3rd handshake -> only 2 writes, no done, IDLE next cycle, wr_count=2.
REQ-038 rst asserted in cycle of 2nd handshake of len=5 -> only 1 write, all outputs 0 next cycle; subsequent start, len=1 works normally.
